// File: rtl/riscv_if_stage_if.sv
// riscv_if_stage_if: instruction-memory req/ack bus between the fetch stage and imem
interface riscv_if_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  modport master(output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave(input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/riscv_if_stage.sv
// riscv_if_stage: instruction fetch, owns the PC, one registered slot to decode, branch redirect/kill
module riscv_if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall_i,
  input  logic                    br_i,
  input  logic [31:0]             br_pc_i,
  riscv_if_stage_if.master        imem,
  output logic                    inst_valid_o,
  output logic [31:0]             inst_o,
  output logic [31:0]             pc_o,
  output logic                    misalign_o
);
  typedef enum logic [1:0] {IDLE, REQ, FULL, KILL} state_t;
  state_t r_state, w_next;
  logic [31:0] r_pc, r_fetch_addr, r_inst, r_pc_o, w_br_pc, w_seq;
  logic r_valid, r_misalign, w_req, w_ack, w_fill, w_keep;
  assign w_br_pc = {br_pc_i[31:2], 2'b00};
  assign w_seq = r_fetch_addr + 32'd4;
  assign w_fill = w_ack && r_state == REQ && !br_i;
  assign w_keep = r_valid && stall_i && !br_i;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    if (br_i) w_next = (w_req && !w_ack) ? KILL : REQ;
    else w_next = (r_state == IDLE) ? REQ :
                  (r_state == REQ)  ? (w_req ? REQ : FULL) :
                  (r_state == FULL) ? (stall_i ? FULL : REQ) :
                  (w_ack ? REQ : KILL);
  end
  // A new fetch is only raised while the slot is empty or draining, so an ack always has room
  always_comb begin
    w_req = (r_state == REQ && (!r_valid || !stall_i)) || r_state == KILL;
    w_ack = w_req && imem.imem_ack;
    imem.imem_req = w_req;
    imem.imem_addr = {r_fetch_addr[31:2], 2'b00};
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_pc         <= RESET_PC;
      r_fetch_addr <= RESET_PC;
      r_valid      <= 1'b0;
      r_inst       <= NOP_INST;
      r_pc_o       <= RESET_PC;
      r_misalign   <= 1'b0;
    end else begin
      r_misalign   <= br_i && (br_pc_i[1:0] != 2'b00);
      r_pc         <= br_i ? w_br_pc : (w_ack && r_state == REQ) ? w_seq : r_pc;
      r_fetch_addr <= br_i ? ((w_req && !w_ack) ? r_fetch_addr : w_br_pc) :
                      (r_state == IDLE) ? r_pc :
                      !w_ack ? r_fetch_addr :
                      (r_state == REQ) ? w_seq : r_pc;
      r_valid      <= w_fill || w_keep;
      r_inst       <= w_fill ? imem.imem_rdata : w_keep ? r_inst : NOP_INST;
      r_pc_o       <= w_fill ? r_fetch_addr : r_pc_o;
    end
  assign inst_valid_o = r_valid;
  assign inst_o = r_inst;
  assign pc_o = r_pc_o;
  assign misalign_o = r_misalign;
endmodule
